// File: rtl/uop_pkg.sv
// Shared types for the micro-op fetch stage.
// Bundles are sized for FETCH_WIDTH_MAX slots; unused slots are zeroed.
package uop_pkg;

  localparam int FETCH_WIDTH_MAX = 4;

  typedef logic [31:0] fetched_instruction;

  typedef struct packed {
    fetched_instruction [FETCH_WIDTH_MAX-1:0] slot;
    logic [FETCH_WIDTH_MAX-1:0]               slot_valid;
  } bundle_t;

  function automatic logic [31:0] uop_addr_inc(
    input logic [31:0] addr,
    input int unsigned size
  );
    return (addr + 32'd1) & (size - 32'd1);
  endfunction

endpackage

// File: rtl/uop_skid_fifo.sv
// Small skid FIFO with flush; push and pop may coincide even when full.
// Storage is left unreset; only pointers and count are cleared.
module uop_skid_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign count    = cnt;
  assign pop_data = mem[rp];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= ptr_inc(wp);
      if (do_pop)  rp <= ptr_inc(rp);
      unique case (1'b1)
        do_push & ~do_pop: cnt <= cnt + 1'b1;
        do_pop & ~do_push: cnt <= cnt - 1'b1;
        default:           cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uop_fetch_multi.sv
// Micro-op fetch stage: uop buffer reads into a skid FIFO, epoch-tagged redirect.
// Optional perf counters when UOP_FETCH_PERF_EN is defined.
module uop_fetch_multi
  import uop_pkg::*;
#(
  parameter int FETCH_WIDTH  = 2,
  parameter int UOP_BUF_SIZE = 64,
  parameter int SKID_DEPTH   = 2,
  localparam int AW = $clog2(UOP_BUF_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [AW-1:0] clear_addr,
  input  logic          uop_avail,
  output logic          uop_rd_en,
  output logic [AW-1:0] uop_addr,
  input  bundle_t       uop_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output bundle_t       out_bundle,
  output logic          stalled
`ifdef UOP_FETCH_PERF_EN
  ,
  output logic [31:0]   perf_stall_cycles,
  output logic [31:0]   perf_bundles
`endif
);

  localparam int CW = $clog2(SKID_DEPTH + 1);

  logic [AW-1:0] addr_q;
  logic          epoch_q;
  logic          inflight_q;
  logic          inflight_epoch_q;

  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  logic          pop, push;
  logic [CW:0]   occ_sum;
  bundle_t       rdata_m;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready & ~clear;
  assign push      = inflight_q & (inflight_epoch_q == epoch_q) & ~clear;

  // Slots + the in-flight return must leave room for one more read.
  assign occ_sum = {1'b0, fifo_count}
                 - (CW+1)'(pop)
                 + (CW+1)'(inflight_q);

  assign uop_rd_en = ~reset & uop_avail & ~clear
                   & ~(fifo_full & ~pop)
                   & (occ_sum < (CW+1)'(SKID_DEPTH));

  assign stalled  = ~reset & uop_avail & ~clear & ~uop_rd_en;
  assign uop_addr = addr_q;

  always_comb begin
    rdata_m = uop_rdata;
    for (int i = 0; i < FETCH_WIDTH_MAX; i++) begin
      if (i >= FETCH_WIDTH) begin
        rdata_m.slot[i]       = '0;
        rdata_m.slot_valid[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q           <= '0;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
    end else if (clear) begin
      addr_q     <= clear_addr;
      epoch_q    <= ~epoch_q;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= uop_rd_en;
      if (uop_rd_en) begin
        addr_q           <= AW'(uop_addr_inc(32'(addr_q), UOP_BUF_SIZE));
        inflight_epoch_q <= epoch_q;
      end
    end
  end

  uop_skid_fifo #(
    .T     (bundle_t),
    .DEPTH (SKID_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .push      (push),
    .push_data (rdata_m),
    .pop       (pop),
    .pop_data  (out_bundle),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef UOP_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_bundles      <= '0;
    end else begin
      if (stalled && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (pop && perf_bundles != '1)
        perf_bundles <= perf_bundles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uop_fetch_multi.sv
// Self-checking bench for uop_fetch_multi against a queue-level reference model.
// Build with UOP_FETCH_PERF_EN to also check the perf counters.
module tb_uop_fetch_multi;
  import uop_pkg::*;

  localparam int FW = 2;
  localparam int BS = 64;
  localparam int AW = 6;
  localparam int SD = 2;

  logic          clk = 1'b0;
  logic          reset, clear, uop_avail, out_ready;
  logic [AW-1:0] clear_addr, uop_addr;
  logic          uop_rd_en, out_valid, stalled;
  bundle_t       uop_rdata, out_bundle;
`ifdef UOP_FETCH_PERF_EN
  logic [31:0]   perf_stall_cycles, perf_bundles;
`endif

  always #5 clk = ~clk;

  uop_fetch_multi #(
    .FETCH_WIDTH  (FW),
    .UOP_BUF_SIZE (BS),
    .SKID_DEPTH   (SD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .clear_addr (clear_addr),
    .uop_avail  (uop_avail),
    .uop_rd_en  (uop_rd_en),
    .uop_addr   (uop_addr),
    .uop_rdata  (uop_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bundle (out_bundle),
    .stalled    (stalled)
`ifdef UOP_FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_bundles      (perf_bundles)
`endif
  );

  bundle_t mem [BS];
  int tests  = 0;
  int failed = 0;

  // Model: FIFO occupancy, in-flight flag, next issue address, head address.
  int m_occ, m_inf, m_addr, m_head, m_stall, m_xfer;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_b(input string tag, input bundle_t got,
                       input bundle_t exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bundle_t rand_bundle();
    bundle_t b;
    for (int i = 0; i < FETCH_WIDTH_MAX; i++) b.slot[i] = $urandom;
    b.slot_valid = 4'($urandom);
    return b;
  endfunction

  function automatic bundle_t exp_bundle(input int a);
    bundle_t b;
    b = mem[a];
    for (int i = FW; i < FETCH_WIDTH_MAX; i++) begin
      b.slot[i]       = '0;
      b.slot_valid[i] = 1'b0;
    end
    return b;
  endfunction

  task automatic model_reset();
    m_occ = 0; m_inf = 0; m_addr = 0; m_head = 0;
    m_stall = 0; m_xfer = 0;
  endtask

  task automatic cycle();
    bit exp_pop, exp_rd, exp_stall;
    logic rd;
    logic [AW-1:0] a;
    @(negedge clk);
    exp_pop   = !reset && !clear && m_occ > 0 && out_ready;
    exp_rd    = !reset && uop_avail && !clear &&
                (m_occ - int'(exp_pop) + m_inf < SD);
    exp_stall = !reset && uop_avail && !clear && !exp_rd;
    chk("out_valid", out_valid, m_occ > 0);
    chk("uop_rd_en", uop_rd_en, exp_rd);
    chk("stalled", stalled, exp_stall);
    chk("uop_addr", uop_addr, m_addr);
`ifdef UOP_FETCH_PERF_EN
    chk("perf_bundles", perf_bundles, m_xfer);
    chk("perf_stall", perf_stall_cycles, m_stall);
`endif
    if (exp_pop) begin
      chk_b("bundle", out_bundle, exp_bundle(m_head));
      m_head = (m_head + 1) % BS;
      m_xfer++;
    end
    if (exp_stall) m_stall++;
    if (reset) begin
      model_reset();
    end else if (clear) begin
      m_occ = 0; m_inf = 0;
      m_addr = int'(clear_addr); m_head = int'(clear_addr);
    end else begin
      m_occ = m_occ - int'(exp_pop) + m_inf;
      m_inf = int'(exp_rd);
      if (exp_rd) m_addr = (m_addr + 1) % BS;
    end
    rd = uop_rd_en;
    a  = uop_addr;
    @(posedge clk);
    #1;
    uop_rdata = rd ? mem[a] : rand_bundle();
  endtask

  initial begin
    bundle_t hold;
    bit seen;
    logic [31:0] pb, ps;
    for (int i = 0; i < BS; i++) begin
      mem[i] = rand_bundle();
      mem[i].slot[0] = {16'hA5A5, 16'(i)};
    end
    reset = 1'b1; clear = 1'b0; clear_addr = '0;
    uop_avail = 1'b0; out_ready = 1'b0; uop_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    uop_avail = 1'b1;
    cycle();

    // Streaming through the address wrap.
    reset = 1'b0; out_ready = 1'b1;
    repeat (72) cycle();

    // Downstream stall: head must hold.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) hold = out_bundle;
      else chk_b("stall_stable", out_bundle, hold);
    end
    chk("stall_full", stalled, 1'b1);
    out_ready = 1'b1;
    repeat (6) cycle();

    // Redirect with a read in flight.
    clear = 1'b1; clear_addr = 6'd17;
    cycle();
    clear = 1'b0;
    chk("clear_out_valid", out_valid, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = out_valid;
    end
    chk("clear_seen", seen, 1'b1);
    chk("clear_tag", out_bundle.slot[0], {16'hA5A5, 16'd17});

    // Bursty availability, random ready and occasional redirects.
    for (int i = 0; i < 300; i++) begin
      uop_avail = i[0];
      out_ready = 1'($urandom);
      clear = ($urandom_range(0, 39) == 0);
      clear_addr = 6'($urandom);
      cycle();
    end
    clear = 1'b0;

    // Reset while stalled with a full FIFO.
    uop_avail = 1'b1; out_ready = 1'b0;
    repeat (6) cycle();
    chk("pre_reset_stall", stalled, 1'b1);
    reset = 1'b1;
    cycle();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_rd_en", uop_rd_en, 1'b0);
    chk("rst_stalled", stalled, 1'b0);
    chk("rst_addr", uop_addr, 6'd0);
    cycle();
    reset = 1'b0;

    // Counter run: transfers then stalls, then a clear.
    out_ready = 1'b1;
    repeat (12) cycle();
    out_ready = 1'b0;
    repeat (6) cycle();
`ifdef UOP_FETCH_PERF_EN
    pb = perf_bundles;
    ps = perf_stall_cycles;
    chk("perf_b_run", pb, m_xfer);
    chk("perf_s_run", ps, m_stall);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("perf_b_clear", perf_bundles, pb);
    chk("perf_s_clear", perf_stall_cycles, ps);
`else
    pb = 32'(m_xfer);
    ps = 32'(m_stall);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
`endif
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
